// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the instruction
// fetch port and the data load/store port. One transaction is in flight at a
// time. The request fields are registered into mem_* when a requester is
// granted, held until mem_ack (or timeout), and completion is reported with a
// one-cycle done pulse to the owner.
//
// Optional feature: define MEM_ARB_RR_EN to alternate grants on simultaneous
// requests (round robin on last_grant). Without it, data always wins a tie.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic [DATA_W-1:0]     i_rdata,
  output logic                  i_done,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [DATA_W/8-1:0]   d_be,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  d_done,
  output logic                  err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ack
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  mem_we_q, mem_we_d;
  logic [DATA_W/8-1:0]   mem_be_q, mem_be_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]     i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]     d_rdata_q, d_rdata_d;
  logic                  i_done_q, i_done_d;
  logic                  d_done_q, d_done_d;
  logic                  err_q, err_d;
  logic                  pick_d;      // 1 = grant goes to the data port
`ifdef MEM_ARB_RR_EN
  logic                  last_d_q, last_d_d;  // last_grant: 1 = DATA, 0 = FETCH
`endif

  // Next-state, arbitration, request capture and completion decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_done_d    = 1'b0;
    d_done_d    = 1'b0;
    err_d       = 1'b0;
    pick_d      = 1'b0;
`ifdef MEM_ARB_RR_EN
    last_d_d    = last_d_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef MEM_ARB_RR_EN
        pick_d = (d_req && i_req) ? !last_d_q : d_req;
`else
        pick_d = d_req;
`endif
        if (i_req || d_req) begin
          cnt_d = 8'd0;
`ifdef MEM_ARB_RR_EN
          last_d_d = pick_d;
`endif
          if (pick_d) begin
            state_d     = GNT_D;
            mem_we_d    = d_we;
            mem_be_d    = d_be;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
          end else begin
            // Fetches are always reads with no byte lanes enabled
            state_d     = GNT_I;
            mem_we_d    = 1'b0;
            mem_be_d    = '0;
            mem_addr_d  = i_addr;
            mem_wdata_d = '0;
          end
        end
      end
      GNT_I, GNT_D: begin
        if (mem_ack) begin
          // An ack on the last allowed cycle still completes normally
          state_d = RESP;
          if (state_q == GNT_I) begin
            i_done_d  = 1'b1;
            i_rdata_d = mem_rdata;
          end else begin
            d_done_d = 1'b1;
            if (!mem_we_q) d_rdata_d = mem_rdata;
          end
        end else if ((cnt_q + 8'd1) == TIMEOUT_C) begin
          state_d  = RESP;
          err_d    = 1'b1;
          i_done_d = (state_q == GNT_I);
          d_done_d = (state_q == GNT_D);
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      err_q       <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_d_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_done_q    <= i_done_d;
      d_done_q    <= d_done_d;
      err_q       <= err_d;
`ifdef MEM_ARB_RR_EN
      last_d_q    <= last_d_d;
`endif
    end
  end

  assign mem_req   = (state_q == GNT_I) || (state_q == GNT_D);
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter (TIMEOUT overridden to 4).
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          i_req, d_req, d_we, mem_ack;
  logic [AW-1:0] i_addr, d_addr;
  logic [3:0]    d_be;
  logic [DW-1:0] d_wdata, mem_rdata;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
  logic          i_done, d_done, err, mem_req, mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;

  int n_checks = 0;
  int n_fail = 0;
  logic [DW-1:0] exp_i = '0;
  logic [DW-1:0] exp_d = '0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_be = '0; d_addr = '0;
    d_wdata = '0; mem_rdata = '0; mem_ack = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 0;
    tick(); tick();
    n_checks++;
    if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata, i_done, d_done, err, i_rdata, d_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: req=%b we=%b be=%h addr=%h wd=%h idone=%b ddone=%b err=%b ird=%h drd=%h required all 0",
               mem_req, mem_we, mem_be, mem_addr, mem_wdata, i_done, d_done, err, i_rdata, d_rdata);
    end
    reset = 1;
    tick();
    n_checks++;
    if ({mem_req, i_done, d_done} !== 3'b000) begin
      n_fail++; $display("FAIL reset_release_idle: req/idone/ddone=%b required 000", {mem_req, i_done, d_done});
    end
  endtask

  task automatic test_fetch();
    i_req = 1; i_addr = 32'h0000_0010;
    tick();                                   // cycle 1
    n_checks++;
    if ({mem_req, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, 4'h0, 32'h0000_0010}) begin
      n_fail++; $display("FAIL fetch_req: req=%b we=%b be=%h addr=%h required 1 0 0 00000010", mem_req, mem_we, mem_be, mem_addr);
    end
    mem_ack = 1; mem_rdata = 32'h0051_0093;
    tick();                                   // cycle 2
    exp_i = 32'h0051_0093;
    n_checks++;
    if ({mem_req, i_done, d_done, err, i_rdata} !== {1'b0, 1'b1, 1'b0, 1'b0, exp_i}) begin
      n_fail++; $display("FAIL fetch_done: req=%b idone=%b ddone=%b err=%b ird=%h required 0 1 0 0 %h", mem_req, i_done, d_done, err, i_rdata, exp_i);
    end
    mem_ack = 0; i_req = 0;
    tick();                                   // cycle 3
    n_checks++;
    if ({mem_req, i_done} !== 2'b00) begin
      n_fail++; $display("FAIL fetch_pulse_len: req=%b idone=%b required 0 0", mem_req, i_done);
    end
  endtask

  task automatic test_store();
    d_req = 1; d_we = 1; d_be = 4'hF; d_addr = 32'h64; d_wdata = 32'hDEAD_BEEF;
    mem_rdata = 32'h1234_5678;
    for (int c = 1; c <= 3; c++) begin
      tick();
      n_checks++;
      if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata, d_done} !== {1'b1, 1'b1, 4'hF, 32'h64, 32'hDEAD_BEEF, 1'b0}) begin
        n_fail++; $display("FAIL store_fields_c%0d: req=%b we=%b be=%h addr=%h wd=%h ddone=%b required 1 1 f 00000064 deadbeef 0",
                           c, mem_req, mem_we, mem_be, mem_addr, mem_wdata, d_done);
      end
    end
    mem_ack = 1;
    tick();
    n_checks++;
    if ({mem_req, d_done, i_done, err, d_rdata} !== {1'b0, 1'b1, 1'b0, 1'b0, exp_d}) begin
      n_fail++; $display("FAIL store_done: req=%b ddone=%b idone=%b err=%b drd=%h required 0 1 0 0 %h", mem_req, d_done, i_done, err, d_rdata, exp_d);
    end
    mem_ack = 0; idle_inputs();
    tick();
  endtask

  task automatic test_tie();
    logic is_d;
    logic [AW-1:0] ea;
    reset = 0;
    tick();
    exp_i = '0; exp_d = '0;
    n_checks++;
    if ({i_rdata, d_rdata} !== 64'h0) begin
      n_fail++; $display("FAIL tie_reset_rdata: ird=%h drd=%h required 0 0", i_rdata, d_rdata);
    end
    reset = 1;
    i_req = 1; i_addr = 32'h100; d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h200;
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
      is_d = (k % 2 == 0);
`else
      is_d = 1'b1;
`endif
      ea = is_d ? 32'h200 : 32'h100;
      tick();
      n_checks++;
      if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, ea}) begin
        n_fail++; $display("FAIL tie_grant_%0d: req=%b we=%b addr=%h required 1 0 %h", k, mem_req, mem_we, mem_addr, ea);
      end
      mem_ack = 1; mem_rdata = 32'hA000_0000 + k;
      tick();
      if (is_d) exp_d = 32'hA000_0000 + k; else exp_i = 32'hA000_0000 + k;
      n_checks++;
      if ({d_done, i_done, err, i_rdata, d_rdata} !== {is_d, !is_d, 1'b0, exp_i, exp_d}) begin
        n_fail++; $display("FAIL tie_done_%0d: ddone=%b idone=%b err=%b ird=%h drd=%h required %b %b 0 %h %h",
                           k, d_done, i_done, err, i_rdata, d_rdata, is_d, !is_d, exp_i, exp_d);
      end
      mem_ack = 0;
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_timeout();
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h300; mem_rdata = 32'hBAD0_BAD0;
    tick();
    for (int c = 1; c <= TO; c++) begin
      n_checks++;
      if ({mem_req, d_done, err} !== 3'b100) begin
        n_fail++; $display("FAIL timeout_wait_c%0d: req=%b ddone=%b err=%b required 1 0 0", c, mem_req, d_done, err);
      end
      tick();
    end
    n_checks++;
    if ({mem_req, d_done, i_done, err, d_rdata} !== {1'b0, 1'b1, 1'b0, 1'b1, exp_d}) begin
      n_fail++; $display("FAIL timeout_done: req=%b ddone=%b idone=%b err=%b drd=%h required 0 1 0 1 %h", mem_req, d_done, i_done, err, d_rdata, exp_d);
    end
    idle_inputs();
    tick();
    n_checks++;
    if ({mem_req, d_done, err} !== 3'b000) begin
      n_fail++; $display("FAIL timeout_idle: req=%b ddone=%b err=%b required 0 0 0", mem_req, d_done, err);
    end
    i_req = 1; i_addr = 32'h20;
    tick();
    mem_ack = 1; mem_rdata = 32'h0000_5555;
    tick();
    exp_i = 32'h0000_5555;
    n_checks++;
    if ({i_done, err, i_rdata} !== {1'b1, 1'b0, exp_i}) begin
      n_fail++; $display("FAIL timeout_next_ok: idone=%b err=%b ird=%h required 1 0 %h", i_done, err, i_rdata, exp_i);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    i_req = 1; i_addr = 32'h40;
    tick();
    n_checks++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h40}) begin
      n_fail++; $display("FAIL rstmid_gnt: req=%b addr=%h required 1 00000040", mem_req, mem_addr);
    end
    reset = 0; mem_ack = 1; mem_rdata = 32'hCCCC_CCCC;
    tick();
    exp_i = '0; exp_d = '0;
    n_checks++;
    if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata, i_done, d_done, err, i_rdata, d_rdata} !== '0) begin
      n_fail++; $display("FAIL rstmid_outputs: req=%b addr=%h idone=%b err=%b ird=%h required all 0", mem_req, mem_addr, i_done, err, i_rdata);
    end
    reset = 1; mem_ack = 0; i_addr = 32'h44;
    tick();
    n_checks++;
    if ({mem_req, i_done, mem_addr} !== {1'b1, 1'b0, 32'h44}) begin
      n_fail++; $display("FAIL rstmid_restart: req=%b idone=%b addr=%h required 1 0 00000044", mem_req, i_done, mem_addr);
    end
    mem_ack = 1; mem_rdata = 32'h4444_0000;
    tick();
    exp_i = 32'h4444_0000;
    n_checks++;
    if ({i_done, err, i_rdata} !== {1'b1, 1'b0, exp_i}) begin
      n_fail++; $display("FAIL rstmid_done: idone=%b err=%b ird=%h required 1 0 %h", i_done, err, i_rdata, exp_i);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_spurious_ack();
    mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if ({mem_req, i_done, d_done, err, i_rdata, d_rdata} !== {4'b0000, exp_i, exp_d}) begin
        n_fail++; $display("FAIL spurious_c%0d: req=%b idone=%b ddone=%b err=%b ird=%h drd=%h required 0 0 0 0 %h %h",
                           c, mem_req, i_done, d_done, err, i_rdata, d_rdata, exp_i, exp_d);
      end
    end
    mem_ack = 0;
    d_req = 1; d_we = 0; d_addr = 32'h500;
    tick();
    n_checks++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h500}) begin
      n_fail++; $display("FAIL spurious_then_req: req=%b addr=%h required 1 00000500", mem_req, mem_addr);
    end
    mem_ack = 1; mem_rdata = 32'h0000_0500;
    tick();
    exp_d = 32'h0000_0500;
    n_checks++;
    if ({d_done, i_done, err, d_rdata} !== {3'b100, exp_d}) begin
      n_fail++; $display("FAIL spurious_then_done: ddone=%b idone=%b err=%b drd=%h required 1 0 0 %h", d_done, i_done, err, d_rdata, exp_d);
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_tie();
    test_timeout();
    test_reset_mid();
    test_spurious_ack();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
